fifo_write_ctrl: RTL
====================

FIFO_WRITE_CTRL -- requirements
Module: fifo_write_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 4: width of the data word, matching the FIFO data width.
REQ-002 The block SHALL have parameter RETRY_GAP, default 2: number of idle wclk cycles between a rejected write and its retry; legal range is 0..15.
REQ-003 The block SHALL have parameter CNT_W, default 8: width of each statistics counter.
REQ-004 wclk  input  1  write-domain clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high; clock wclk.
REQ-006 s_valid  input  1  the upstream source presents a word.
REQ-007 s_data  input  DATA_W  the upstream word.
REQ-008 s_ready  output  1  the block can take a word this cycle; it is combinational from state and mem_full.
REQ-009 w_en  output  1  FIFO write enable.
REQ-010 data_in  output  DATA_W  the word driven to the FIFO.
REQ-011 mem_full  input  1  registered FIFO full/reject flag; it is valid in the cycle after a w_en pulse.
REQ-012 busy  output  1  the block holds an uncommitted word.
REQ-013 wr_count  output  CNT_W  count of committed words; it wraps.
REQ-014 retry_count  output  CNT_W  count of rejected attempts; it saturates.

Function
REQ-015 The block SHALL use states IDLE, WRITE, CHECK and WAIT.
REQ-016 The block SHALL perform a handshake transfer when s_valid && s_ready at a rising edge; the block SHALL then load s_data into hold_data.
REQ-017 s_ready SHALL be 1 only when rst is 0 and either state==IDLE or (state==CHECK && mem_full==0).
REQ-018 IDLE: on a transfer the next state SHALL be WRITE; otherwise the block SHALL remain in IDLE.
REQ-019 WRITE: w_en SHALL be 1 for exactly this cycle, and the next state SHALL be CHECK.
REQ-020 CHECK when mem_full==0:
- the previous word is committed;
- wr_count SHALL increment modulo 2^CNT_W;
- on a simultaneous transfer the block SHALL load the new word and go to WRITE;
- otherwise it SHALL go to IDLE.
REQ-021 CHECK when mem_full==1:
- the previous word was dropped by the FIFO;
- retry_count SHALL increment, saturating at 2^CNT_W-1;
- hold_data SHALL be kept unchanged;
- with RETRY_GAP==0 the next state SHALL be WRITE;
- otherwise the block SHALL load gap_cnt=RETRY_GAP-1 and go to WAIT.
REQ-022 WAIT: gap_cnt SHALL decrement each cycle; when gap_cnt==0 the next state SHALL be WRITE.
REQ-023 w_en SHALL be 0 in every state other than WRITE, so the block never has two writes in flight (stop-and-wait); this SHALL guarantee no reordering or duplication.
REQ-024 data_in SHALL equal hold_data at all times and SHALL be stable from WRITE through CHECK.
REQ-025 busy SHALL be 1 whenever state != IDLE.
REQ-026 Latency: after a transfer at edge k, w_en SHALL be high in cycle k+1 and the commit decision SHALL be sampled at edge k+2.
REQ-027 Peak throughput SHALL be 1 word per 2 wclk cycles.
REQ-028 mem_full SHALL be ignored outside CHECK.
REQ-029 A word SHALL never be discarded by the block except by rst.

Reset
REQ-030 While rst==1 at an edge, the block SHALL set:
- state=IDLE;
- w_en=0;
- hold_data=0, so data_in=0;
- gap_cnt=0;
- wr_count=0;
- retry_count=0;
- busy=0.
REQ-031 While rst==1, s_ready SHALL be 0 and no transfer SHALL occur.
REQ-032 Reset asserted in any state SHALL abandon the held word, and w_en SHALL be 0 in the cycle following the reset edge.
REQ-033 After rst deasserts, s_ready SHALL be 1 in the first cycle.

Verification
REQ-034 Reset: hold rst=1 for 2 cycles with s_valid=1 -> s_ready=0, w_en=0, wr_count=0, retry_count=0; after release s_ready=1.
REQ-035 Single word: s_data=4'hA for one cycle with mem_full=0 -> w_en=1 for exactly one cycle with data_in=4'hA; wr_count=1; busy returns to 0.
REQ-036 Back-to-back: words 4'h1, 4'h2, 4'h3 with s_valid held, mem_full=0 -> w_en pattern 1,0,1,0,1 with data_in 1,2,3; wr_count=3; no drops.
REQ-037 Reject/retry with RETRY_GAP=2: drive mem_full=1 in the first CHECK -> WAIT for 2 cycles; w_en re-pulses 4 cycles after the first pulse with the same data; retry_count=1; s_ready=0 throughout; the commit on the second attempt gives wr_count=1.
REQ-038 Reset mid-retry: assert rst during WAIT -> the next cycle is IDLE with w_en=0 and counters=0; no retry pulse occurs.
REQ-039 Saturation: force 260 consecutive rejects -> retry_count holds at 255 and the held word is unchanged.

Source files
------------

// File: rtl/fifo_write_ctrl.sv
// fifo_write_ctrl
//   Stop-and-wait write controller for a FIFO that reports rejected writes
//   through a registered full flag. It accepts one word from the source,
//   writes it, and checks the reject flag in the following cycle. A rejected
//   word is retried after RETRY_GAP idle cycles and is never dropped.
//
// Parameters
//   DATA_W     data word width
//   RETRY_GAP  idle cycles between a rejected write and its retry (0..15)
//   CNT_W      statistics counter width
//
// Ports
//   wclk         write-domain clock
//   rst          synchronous active-high reset
//   s_valid      source presents a word
//   s_data       source word
//   s_ready      block accepts a word this cycle (combinational)
//   w_en         FIFO write enable
//   data_in      word driven to the FIFO (always the held word)
//   mem_full     FIFO reject flag, meaningful in the cycle after w_en
//   busy         an uncommitted word is held
//   wr_count     committed words, wraps
//   retry_count  rejected attempts, saturates
//
// state | meaning
// IDLE  | nothing held, ready for a new word
// WRITE | w_en asserted for the held word
// CHECK | reject flag sampled; commit or schedule a retry
// WAIT  | idle gap before the retry
module fifo_write_ctrl #(
  parameter int DATA_W    = 4,
  parameter int RETRY_GAP = 2,
  parameter int CNT_W     = 8
) (
  input  logic              wclk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              w_en,
  output logic [DATA_W-1:0] data_in,
  input  logic              mem_full,
  output logic              busy,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  retry_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CHECK = 2'd2,
    WAIT  = 2'd3
  } state_t;

  // The down-counter is loaded with one less than the gap because the
  // terminal cycle (gap_cnt==0) is itself one of the idle cycles.
  localparam logic [3:0]       GAP_LOAD = (RETRY_GAP > 0) ? 4'(RETRY_GAP - 1) : 4'd0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] hold_data, hold_nxt;
  logic [3:0]        gap_cnt, gap_nxt;
  logic              xfer;
  logic              commit;
  logic              reject;

  assign s_ready = !rst && ((state == IDLE) || ((state == CHECK) && !mem_full));
  assign xfer    = s_valid && s_ready;
  assign w_en    = (state == WRITE);
  assign data_in = hold_data;
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_data;
    gap_nxt   = gap_cnt;
    commit    = 1'b0;
    reject    = 1'b0;
    case (state)
      IDLE: begin
        if (xfer) begin
          hold_nxt  = s_data;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        state_nxt = CHECK;
      end
      CHECK: begin
        if (!mem_full) begin
          commit = 1'b1;
          if (xfer) begin
            hold_nxt  = s_data;
            state_nxt = WRITE;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          reject = 1'b1;
          if (RETRY_GAP == 0) begin
            state_nxt = WRITE;
          end else begin
            gap_nxt   = GAP_LOAD;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (gap_cnt == 4'd0) begin
          state_nxt = WRITE;
        end else begin
          gap_nxt = gap_cnt - 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge wclk) begin
    if (rst) begin
      state       <= IDLE;
      hold_data   <= '0;
      gap_cnt     <= 4'd0;
      wr_count    <= '0;
      retry_count <= '0;
    end else begin
      state     <= state_nxt;
      hold_data <= hold_nxt;
      gap_cnt   <= gap_nxt;
      if (commit) begin
        wr_count <= wr_count + 1'b1;
      end
      if (reject && (retry_count != CNT_MAX)) begin
        retry_count <= retry_count + 1'b1;
      end
    end
  end

endmodule
